rob_tracker: RTL and testbench

//   Reorder-buffer occupancy and tag manager. Consumes rob_increment (allocate) and
//   rob_decrement (retire request) from hazard_detection and produces the rob_full

---
 rtl/rob_tracker.sv | 163 ++++++++++++++++
 tb/tb_rob_tracker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rob_tracker.sv
// -----------------------------------------------------------------------------
// rob_tracker
//   Reorder-buffer occupancy and tag manager.
//   - Hands out in-order tags at the tail.
//   - Tracks per-entry valid/done state.
//   - Retires the head entry in program order once it is done.
//   - Flags full/empty for frontend stall gating.
//
// Optional feature macro: ROB_PERF_CNT_EN
//   When defined, adds perf_full_stalls. It counts cycles with
//   rob_full && rob_increment, saturates, and is cleared by reset only.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   reset            asynchronous, active-low clear of all state
//   rob_increment    allocate one entry at the tail
//   rob_decrement    retire request for the head entry
//   complete_valid   an execution result is being written back
//   complete_tag     tag of the completing entry
//   flush            squash every entry
//   rob_full         count == ROB_DEPTH
//   rob_empty        count == 0
//   rob_count        occupied entries, 0..ROB_DEPTH
//   alloc_tag        tag the next accepted allocation receives
//   head_tag         tag of the oldest entry
//   retire_valid     registered 1-cycle pulse: an entry retired
//   retire_tag       tag that retired (meaningful with retire_valid)
//   rob_overflow     registered 1-cycle pulse: allocation dropped while full
//   perf_full_stalls (ROB_PERF_CNT_EN only) saturating full-stall cycle count
// -----------------------------------------------------------------------------
module rob_tracker #(
   parameter  int ROB_DEPTH = 16,
   localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rob_increment,
   input  logic             rob_decrement,
   input  logic             complete_valid,
   input  logic [TAG_W-1:0] complete_tag,
   input  logic             flush,
   output logic             rob_full,
   output logic             rob_empty,
   output logic [TAG_W:0]   rob_count,
   output logic [TAG_W-1:0] alloc_tag,
   output logic [TAG_W-1:0] head_tag,
   output logic             retire_valid,
   output logic [TAG_W-1:0] retire_tag,
   output logic             rob_overflow
`ifdef ROB_PERF_CNT_EN
   ,
   output logic [31:0]      perf_full_stalls
`endif
);

   localparam logic [TAG_W:0] DEPTH_CNT = ROB_DEPTH[TAG_W:0];
   localparam logic [TAG_W:0] PTR_ONE   = {{TAG_W{1'b0}}, 1'b1};

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [TAG_W:0]         head_reg, tail_reg;
   logic [ROB_DEPTH-1:0]   valid_reg, done_reg;
   logic [ROB_DEPTH-1:0]   valid_next, done_next;
   logic                   retire_valid_reg, rob_overflow_reg;
   logic [TAG_W-1:0]       retire_tag_reg;

   logic [TAG_W:0]         count;
   logic [TAG_W-1:0]       head_idx, tail_idx;
   logic                   alloc_ok, retire_ok, complete_ok;

   assign count     = tail_reg - head_reg;
   assign head_idx  = head_reg[TAG_W-1:0];
   assign tail_idx  = tail_reg[TAG_W-1:0];

   assign rob_count = count;
   assign rob_full  = (count == DEPTH_CNT);
   assign rob_empty = (count == '0);
   assign alloc_tag = tail_idx;
   assign head_tag  = head_idx;

   assign retire_valid = retire_valid_reg;
   assign retire_tag   = retire_tag_reg;
   assign rob_overflow = rob_overflow_reg;

   // All three operations are judged against start-of-cycle state.
   // The slot freed by a retire is therefore not reusable in the same cycle.
   assign alloc_ok    = rob_increment && !rob_full;
   assign retire_ok   = rob_decrement && !rob_empty && done_reg[head_idx];
   assign complete_ok = complete_valid && valid_reg[complete_tag];

   // Per-entry next state.
   // Alloc and retire can only target the same slot when the ROB is empty
   // or full, and in those cases one of them is already disabled.
   // A completion aimed at a slot being allocated cannot see valid=1,
   // so the allocation keeps done at 0.
   generate
      for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
         logic alloc_here, retire_here, complete_here;
         assign alloc_here    = alloc_ok    && (tail_idx     == TAG_W'(gi));
         assign retire_here   = retire_ok   && (head_idx     == TAG_W'(gi));
         assign complete_here = complete_ok && (complete_tag == TAG_W'(gi));

         always_comb begin
            valid_next[gi] = valid_reg[gi];
            done_next[gi]  = done_reg[gi];
            if (flush) begin
               valid_next[gi] = 1'b0;
               done_next[gi]  = 1'b0;
            end else if (alloc_here) begin
               valid_next[gi] = 1'b1;
               done_next[gi]  = 1'b0;
            end else if (retire_here) begin
               valid_next[gi] = 1'b0;
               done_next[gi]  = 1'b0;
            end else if (complete_here) begin
               done_next[gi]  = 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_reg         <= '0;
         tail_reg         <= '0;
         valid_reg        <= '0;
         done_reg         <= '0;
         retire_valid_reg <= 1'b0;
         retire_tag_reg   <= '0;
         rob_overflow_reg <= 1'b0;
      end else begin
         valid_reg <= valid_next;
         done_reg  <= done_next;
         if (flush) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            retire_valid_reg <= 1'b0;
            rob_overflow_reg <= 1'b0;
         end else begin
            if (alloc_ok)  tail_reg <= tail_reg + PTR_ONE;
            if (retire_ok) begin
               head_reg       <= head_reg + PTR_ONE;
               retire_tag_reg <= head_idx;
            end
            retire_valid_reg <= retire_ok;
            rob_overflow_reg <= rob_increment && rob_full;
         end
      end
   end

`ifdef ROB_PERF_CNT_EN
   // Flush does not clear this counter; only reset does.
   logic [31:0] perf_reg;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_reg <= '0;
      end else if (rob_full && rob_increment && (perf_reg != 32'hFFFF_FFFF)) begin
         perf_reg <= perf_reg + 32'd1;
      end
   end
   assign perf_full_stalls = perf_reg;
`endif

endmodule

// File: tb/tb_rob_tracker.sv
// -----------------------------------------------------------------------------
// tb_rob_tracker
//   Self-checking bench for rob_tracker (ROB_DEPTH = 16).
//   The reference model keeps the in-flight tags as an ordered queue and
//   holds a done flag per tag. Directed scenarios run first, followed by
//   a randomized stream that includes an asynchronous mid-cycle reset.
// -----------------------------------------------------------------------------
module tb_rob_tracker;
   localparam int D     = 16;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             rob_increment = 1'b0, rob_decrement = 1'b0;
   logic             complete_valid = 1'b0, flush = 1'b0;
   logic [TAG_W-1:0] complete_tag = '0;
   logic             rob_full, rob_empty, retire_valid, rob_overflow;
   logic [TAG_W:0]   rob_count;
   logic [TAG_W-1:0] alloc_tag, head_tag, retire_tag;
`ifdef ROB_PERF_CNT_EN
   logic [31:0]      perf_full_stalls;
`endif

   rob_tracker #(.ROB_DEPTH(D)) dut (
      .clk(clk), .reset(reset),
      .rob_increment(rob_increment), .rob_decrement(rob_decrement),
      .complete_valid(complete_valid), .complete_tag(complete_tag),
      .flush(flush),
      .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count),
      .alloc_tag(alloc_tag), .head_tag(head_tag),
      .retire_valid(retire_valid), .retire_tag(retire_tag),
      .rob_overflow(rob_overflow)
`ifdef ROB_PERF_CNT_EN
      , .perf_full_stalls(perf_full_stalls)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int  q[$];          // in-flight tags, oldest first
   bit  m_done[D];
   int  m_head;
   bit  exp_rv, exp_ovf;
   int  exp_rtag;
   longint m_perf;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit in_rob(input int t);
      foreach (q[i]) if (q[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      q.delete();
      foreach (m_done[i]) m_done[i] = 1'b0;
      m_head = 0; exp_rv = 0; exp_ovf = 0; exp_rtag = 0; m_perf = 0;
   endtask

   task automatic chk_all(input string ctx);
      chk({ctx, ".count"},     32'(rob_count),    32'(q.size()));
      chk({ctx, ".full"},      32'(rob_full),     32'(q.size() == D));
      chk({ctx, ".empty"},     32'(rob_empty),    32'(q.size() == 0));
      chk({ctx, ".alloc_tag"}, 32'(alloc_tag),    32'((m_head + q.size()) % D));
      chk({ctx, ".head_tag"},  32'(head_tag),     32'(m_head));
      chk({ctx, ".retire_v"},  32'(retire_valid), 32'(exp_rv));
      if (exp_rv) chk({ctx, ".retire_tag"}, 32'(retire_tag), 32'(exp_rtag));
      chk({ctx, ".overflow"},  32'(rob_overflow), 32'(exp_ovf));
`ifdef ROB_PERF_CNT_EN
      chk({ctx, ".perf"},      perf_full_stalls,  32'(m_perf));
`endif
   endtask

   // One clock: drive inputs, predict from start-of-cycle state, check after the edge.
   task automatic step(input string ctx, input bit inc, input bit dec,
                       input bit cv, input int ctag, input bit fl);
      bit full_s, empty_s, ret, alc, cmp;
      int new_tag, rt;
      rob_increment  = inc;
      rob_decrement  = dec;
      complete_valid = cv;
      complete_tag   = ctag[TAG_W-1:0];
      flush          = fl;
      full_s  = (q.size() == D);
      empty_s = (q.size() == 0);
      if (full_s && inc) m_perf++;
      if (fl) begin
         q.delete();
         foreach (m_done[i]) m_done[i] = 1'b0;
         m_head = 0; exp_rv = 0; exp_ovf = 0;
      end else begin
         ret     = dec && !empty_s && m_done[q[0]];
         alc     = inc && !full_s;
         cmp     = cv && in_rob(ctag % D);
         new_tag = (m_head + q.size()) % D;
         exp_ovf = inc && full_s;
         if (cmp) m_done[ctag % D] = 1'b1;
         if (ret) begin
            rt = q.pop_front();
            m_done[rt] = 1'b0;
            m_head = (rt + 1) % D;
            exp_rtag = rt;
         end
         if (alc) begin
            q.push_back(new_tag);
            m_done[new_tag] = 1'b0;
         end
         exp_rv = ret;
      end
      @(posedge clk);
      #1;
      chk_all(ctx);
   endtask

   initial begin
      int t;
      bit inc, dec, cv, fl;
      model_reset();
      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset");
      chk("reset.retire_tag", 32'(retire_tag), 32'd0);
      reset = 1'b1;

      // 1: fill to 16, then one rejected allocation.
      for (int i = 0; i < D; i++) begin
         chk("t1.alloc_seq", 32'(alloc_tag), 32'(i));
         step("t1.fill", 1, 0, 0, 0, 0);
      end
      step("t1.over", 1, 0, 0, 0, 0);
      step("t1.idle", 0, 0, 0, 0, 0);

      // 2: out-of-order completion cannot retire past an incomplete head.
      step("t2.flush", 0, 0, 0, 0, 1);
      repeat (4) step("t2.alloc", 1, 0, 0, 0, 0);
      step("t2.cmp3", 0, 0, 1, 3, 0);
      step("t2.dec_nr", 0, 1, 0, 0, 0);
      step("t2.cmp0", 0, 0, 1, 0, 0);
      step("t2.dec", 0, 1, 0, 0, 0);
      step("t2.idle", 0, 0, 0, 0, 0);

      // 3: full + retire + allocate -> retire only, overflow pulses.
      while (q.size() < D) step("t3.fill", 1, 0, 0, 0, 0);
      step("t3.cmp_head", 0, 0, 1, m_head, 0);
      step("t3.both", 1, 1, 0, 0, 0);
      step("t3.idle", 0, 0, 0, 0, 0);

      // 4: single-entry stream wraps the tags twice.
      step("t4.flush", 0, 0, 0, 0, 1);
      for (int i = 0; i < 40; i++) begin
         step("t4.alloc", 1, 0, 0, 0, 0);
         step("t4.cmp", 0, 0, 1, m_head, 0);
         step("t4.ret", 0, 1, 0, 0, 0);
      end

      // 5: flush wins over simultaneous alloc/complete/retire.
      step("t5.flush0", 0, 0, 0, 0, 1);
      repeat (7) step("t5.alloc", 1, 0, 0, 0, 0);
      step("t5.cmp", 0, 0, 1, m_head, 0);
      step("t5.flush", 1, 1, 1, 1, 1);

      // Randomized stream with an async reset in the middle.
      for (int i = 0; i < 800; i++) begin
         inc = ($urandom_range(99) < 55);
         dec = ($urandom_range(99) < 50);
         cv  = ($urandom_range(99) < 70);
         fl  = ($urandom_range(99) < 2);
         if (q.size() > 0 && $urandom_range(3) != 0)
            t = q[$urandom_range(q.size() - 1)];
         else
            t = $urandom_range(D - 1);
         step("rnd", inc, dec, cv, t, fl);
         if (i == 400) begin
            // 6: asynchronous reset between clock edges.
            #2 reset = 1'b0;
            #1;
            model_reset();
            chk_all("t6.async");
            chk("t6.retire_tag", 32'(retire_tag), 32'd0);
            #2 reset = 1'b1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
